// File: rtl/vliw_regfile_2w4r.sv
// Two-write / four-read architectural register file for the two-slot VLIW
// datapath. Same-cycle writebacks are bypassed to all readers (slot 2 has
// priority over slot 1), and a per-register pending-write scoreboard drives
// per-slot stall requests. All state updates happen on the falling clock edge.
module vliw_regfile_2w4r #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_1,
  input  logic [ADDR_W-1:0]   wr_addr_1,
  input  logic [DATA_W-1:0]   wr_data_1,
  input  logic                wr_en_2,
  input  logic [ADDR_W-1:0]   wr_addr_2,
  input  logic [DATA_W-1:0]   wr_data_2,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic                rd_en_c,
  input  logic [ADDR_W-1:0]   rd_addr_c,
  input  logic                rd_en_d,
  input  logic [ADDR_W-1:0]   rd_addr_d,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic [DATA_W-1:0]   rd_data_c,
  output logic [DATA_W-1:0]   rd_data_d,
  input  logic                issue_en_1,
  input  logic [ADDR_W-1:0]   issue_dst_1,
  input  logic                issue_en_2,
  input  logic [ADDR_W-1:0]   issue_dst_2,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                hazard_1,
  output logic                hazard_2
);

  localparam int NUM_RD = 4;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [NUM_REGS-1:0]             set_vec, clr_vec, effbusy;

  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]               rd_en;
  logic [NUM_RD-1:0]               rd_haz;

  assign rd_addr = {rd_addr_d, rd_addr_c, rd_addr_b, rd_addr_a};
  assign rd_en   = {rd_en_d,   rd_en_c,   rd_en_b,   rd_en_a};

  // Per-register issue (set) and writeback (clear) decode, plus next busy state.
  // A new producer issued while the old one retires keeps the bit set.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_vec[i] = (issue_en_1 && issue_dst_1 == ADDR_W'(i)) ||
                   (issue_en_2 && issue_dst_2 == ADDR_W'(i));
      clr_vec[i] = (wr_en_1 && wr_addr_1 == ADDR_W'(i)) ||
                   (wr_en_2 && wr_addr_2 == ADDR_W'(i));
    end
    busy_d  = set_vec | (busy_q & ~clr_vec);
    // A register being written this cycle is bypassed, so it does not stall.
    effbusy = busy_q & ~clr_vec;
  end

  // Per-port read mux with writeback bypass; slot 2 is later in program order.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    always_comb begin
      if (wr_en_2 && wr_addr_2 == rd_addr[p])      rd_data[p] = wr_data_2;
      else if (wr_en_1 && wr_addr_1 == rd_addr[p]) rd_data[p] = wr_data_1;
      else                                         rd_data[p] = regs_q[rd_addr[p]];
      rd_haz[p] = rd_en[p] && effbusy[rd_addr[p]];
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign rd_data_c = rd_data[2];
  assign rd_data_d = rd_data[3];
  assign hazard_1  = rd_haz[0] | rd_haz[1];
  assign hazard_2  = rd_haz[2] | rd_haz[3];
  assign busy_vec  = busy_q;

  // Register array and scoreboard; slot-2 write is applied last so it wins
  // an address conflict. Reset overrides any concurrent write or issue.
  always_ff @(negedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      if (wr_en_1) regs_q[wr_addr_1] <= wr_data_1;
      if (wr_en_2) regs_q[wr_addr_2] <= wr_data_2;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_vliw_regfile_2w4r.sv
// Bench for vliw_regfile_2w4r: directed plan followed by random traffic,
// every cycle compared against a behavioural array/scoreboard model.
module tb_vliw_regfile_2w4r;
  localparam int NR = 8, AW = 3, DW = 32;

  logic clk = 1'b1;
  logic reset;
  logic wr_en_1, wr_en_2, rd_en_a, rd_en_b, rd_en_c, rd_en_d, issue_en_1, issue_en_2;
  logic [AW-1:0] wr_addr_1, wr_addr_2, rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d;
  logic [AW-1:0] issue_dst_1, issue_dst_2;
  logic [DW-1:0] wr_data_1, wr_data_2, rd_data_a, rd_data_b, rd_data_c, rd_data_d;
  logic [NR-1:0] busy_vec;
  logic hazard_1, hazard_2;

  always #5 clk = ~clk;

  vliw_regfile_2w4r #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .wr_en_2(wr_en_2), .wr_addr_2(wr_addr_2), .wr_data_2(wr_data_2),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_en_c(rd_en_c), .rd_addr_c(rd_addr_c), .rd_en_d(rd_en_d), .rd_addr_d(rd_addr_d),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c), .rd_data_d(rd_data_d),
    .issue_en_1(issue_en_1), .issue_dst_1(issue_dst_1),
    .issue_en_2(issue_en_2), .issue_dst_2(issue_dst_2),
    .busy_vec(busy_vec), .hazard_1(hazard_1), .hazard_2(hazard_2)
  );

  // Behavioural model state
  logic [DW-1:0] mreg [NR];
  bit            mbusy[NR];
  bit            armed = 0;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit written(input logic [AW-1:0] a);
    return (wr_en_1 && wr_addr_1 == a) || (wr_en_2 && wr_addr_2 == a);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (wr_en_2 && wr_addr_2 == a) return wr_data_2;
    if (wr_en_1 && wr_addr_1 == a) return wr_data_1;
    return mreg[a];
  endfunction

  function automatic bit stall(input logic en, input logic [AW-1:0] a);
    return en && mbusy[a] && !written(a);
  endfunction

  // Model update on the active (falling) edge
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        mreg[i]  <= '0;
        mbusy[i] <= 1'b0;
      end
      armed <= 1'b1;
    end else begin
      if (wr_en_1) mreg[wr_addr_1] <= wr_data_1;
      if (wr_en_2) mreg[wr_addr_2] <= wr_data_2;
      for (int i = 0; i < NR; i++) begin
        if ((issue_en_1 && issue_dst_1 == AW'(i)) || (issue_en_2 && issue_dst_2 == AW'(i)))
          mbusy[i] <= 1'b1;
        else if (written(AW'(i)))
          mbusy[i] <= 1'b0;
      end
    end
  end

  // Compare process: inputs change at posedge+1, outputs sampled at posedge+3
  always @(posedge clk) begin
    logic [NR-1:0] eb;
    #3;
    if (armed) begin
      for (int i = 0; i < NR; i++) eb[i] = mbusy[i];
      chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
      chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
      chk("rd_data_c", rd_data_c, exp_rd(rd_addr_c));
      chk("rd_data_d", rd_data_d, exp_rd(rd_addr_d));
      chk("busy_vec", 32'(busy_vec), 32'(eb));
      chk("hazard_1", 32'(hazard_1), 32'(stall(rd_en_a, rd_addr_a) | stall(rd_en_b, rd_addr_b)));
      chk("hazard_2", 32'(hazard_2), 32'(stall(rd_en_c, rd_addr_c) | stall(rd_en_d, rd_addr_d)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_1 = 0; wr_en_2 = 0; issue_en_1 = 0; issue_en_2 = 0;
    rd_en_a = 0; rd_en_b = 0; rd_en_c = 0; rd_en_d = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    wr_addr_1 = 0; wr_addr_2 = 0; wr_data_1 = 0; wr_data_2 = 0;
    rd_addr_a = 0; rd_addr_b = 0; rd_addr_c = 0; rd_addr_d = 0;
    issue_dst_1 = 0; issue_dst_2 = 0;
    tick(); tick();
    reset = 0;

    // Reset state: every address reads zero, nothing busy, no hazard
    for (int a = 0; a < NR; a++) begin
      rd_addr_a = AW'(a); rd_addr_b = AW'(a); rd_addr_c = AW'(a); rd_addr_d = AW'(a);
      rd_en_a = 1; rd_en_b = 1; rd_en_c = 1; rd_en_d = 1;
      #1;
      chk("lit_reset_rd_a", rd_data_a, 32'h0);
      chk("lit_reset_rd_d", rd_data_d, 32'h0);
      tick();
    end
    chk("lit_reset_busy", 32'(busy_vec), 32'h0);
    chk("lit_reset_haz", 32'({hazard_1, hazard_2}), 32'h0);
    idle();

    // Dual write r3/r5 with same-cycle bypass on port c
    wr_en_1 = 1; wr_addr_1 = 3; wr_data_1 = 32'hDEADBEEF;
    wr_en_2 = 1; wr_addr_2 = 5; wr_data_2 = 32'h12345678;
    rd_addr_c = 3;
    #1 chk("lit_bypass_c", rd_data_c, 32'hDEADBEEF);
    tick();
    idle();
    rd_addr_a = 3; rd_addr_b = 5;
    #1;
    chk("lit_r3", rd_data_a, 32'hDEADBEEF);
    chk("lit_r5", rd_data_b, 32'h12345678);
    tick();

    // Write conflict on r2: slot 2 wins
    wr_en_1 = 1; wr_addr_1 = 2; wr_data_1 = 32'h11111111;
    wr_en_2 = 1; wr_addr_2 = 2; wr_data_2 = 32'h22222222;
    rd_addr_a = 2;
    #1 chk("lit_conflict_bypass", rd_data_a, 32'h22222222);
    tick();
    idle();
    #1;
    chk("lit_conflict_stored", rd_data_a, 32'h22222222);
    chk("lit_model_r2", mreg[2], 32'h22222222);
    tick();

    // Scoreboard: issue r4, hazard, retire with bypass
    issue_en_1 = 1; issue_dst_1 = 4;
    tick();
    idle();
    rd_en_c = 1; rd_addr_c = 4;
    #1;
    chk("lit_busy_r4", 32'(busy_vec), 32'h10);
    chk("lit_haz2_set", 32'(hazard_2), 32'h1);
    tick();
    wr_en_1 = 1; wr_addr_1 = 4; wr_data_1 = 32'hCAFE0001;
    #1;
    chk("lit_haz2_drop", 32'(hazard_2), 32'h0);
    chk("lit_bypass_r4", rd_data_c, 32'hCAFE0001);
    tick();
    idle();
    #1 chk("lit_busy_clear", 32'(busy_vec), 32'h0);
    tick();

    // Set beats clear on r6
    issue_en_2 = 1; issue_dst_2 = 6;
    tick();
    wr_en_1 = 1; wr_addr_1 = 6; wr_data_1 = 32'h66666666;
    tick();
    idle();
    #1 chk("lit_set_beats_clr", 32'(busy_vec), 32'h40);
    tick();

    // Reset overrides concurrent write and issue
    reset = 1;
    wr_en_1 = 1; wr_addr_1 = 1; wr_data_1 = 32'hFFFFFFFF;
    issue_en_1 = 1; issue_dst_1 = 7;
    tick();
    reset = 0;
    idle();
    rd_addr_a = 1;
    #1;
    chk("lit_reset_r1", rd_data_a, 32'h0);
    chk("lit_reset_busy2", 32'(busy_vec), 32'h0);
    tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(63) == 0);
      wr_en_1    = $urandom_range(1);  wr_addr_1 = AW'($urandom); wr_data_1 = $urandom;
      wr_en_2    = $urandom_range(1);  wr_addr_2 = AW'($urandom); wr_data_2 = $urandom;
      rd_en_a    = $urandom_range(1);  rd_addr_a = AW'($urandom);
      rd_en_b    = $urandom_range(1);  rd_addr_b = AW'($urandom);
      rd_en_c    = $urandom_range(1);  rd_addr_c = AW'($urandom);
      rd_en_d    = $urandom_range(1);  rd_addr_d = AW'($urandom);
      issue_en_1 = ($urandom_range(2) == 0); issue_dst_1 = AW'($urandom);
      issue_en_2 = ($urandom_range(2) == 0); issue_dst_2 = AW'($urandom);
      tick();
    end
    reset = 0;
    idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vliw_regfile_2w4r.md
Name: vliw_regfile_2w4r

Overview:
- Architectural register file for the two-slot VLIW datapath.
- Sits directly downstream of the per-slot writeback stages and upstream of operand fetch.
- Accepts one write per slot per cycle, serves four read ports (two per slot), and bypasses same-cycle writebacks to readers.
- Keeps a pending-write scoreboard so decode can stall a slot whose source has an in-flight producer.

Parameters:
- NUM_REGS, 8, number of architectural registers; must equal 2**ADDR_W.
- ADDR_W, 3, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  single clock; all state updates on the falling edge, same as every other register in the codebase.
- reset  input  1  synchronous, active-high; sampled on the falling edge of clk.
- wr_en_1  input  1  slot-1 writeback enable.
- wr_addr_1  input  ADDR_W  slot-1 destination register.
- wr_data_1  input  DATA_W  slot-1 result.
- wr_en_2  input  1  slot-2 writeback enable.
- wr_addr_2  input  ADDR_W  slot-2 destination register.
- wr_data_2  input  DATA_W  slot-2 result.
- rd_en_a, rd_en_b  input  1 each  slot-1 source valids; used only for hazard detection.
- rd_addr_a, rd_addr_b  input  ADDR_W each  slot-1 source addresses.
- rd_en_c, rd_en_d  input  1 each  slot-2 source valids; used only for hazard detection.
- rd_addr_c, rd_addr_d  input  ADDR_W each  slot-2 source addresses.
- rd_data_a..rd_data_d  output  DATA_W each  read data.
- issue_en_1, issue_en_2  input  1 each  slot issues an instruction that will write a register.
- issue_dst_1, issue_dst_2  input  ADDR_W each  destination of the issued instruction.
- busy_vec  output  NUM_REGS  scoreboard; bit i = register i has a pending write.
- hazard_1  output  1  slot-1 must stall.
- hazard_2  output  1  slot-2 must stall.

Behaviour:
- Reset: on a falling edge with reset=1, all registers clear to 0 and busy_vec clears to 0.
  - Reset overrides any concurrent write or issue.
  - After reset, rd_data_* = 0 for every address, and hazard_1 = hazard_2 = 0.
- Write:
  - On the falling edge, reg[wr_addr_k] <= wr_data_k when wr_en_k=1.
  - Every register is writable; there is no hardwired zero.
- Write conflict: wr_en_1 = wr_en_2 = 1 with wr_addr_1 == wr_addr_2 → slot 2 wins (later in program order). Slot-1 data is discarded.
- Read: combinational, zero latency. Priority per port:
  1. wr_data_2 when wr_en_2 and addr match;
  2. else wr_data_1 when wr_en_1 and addr match;
  3. else stored value.
  - All four ports are independent; identical addresses on several ports are legal.
- Scoreboard update per register i on the falling edge:
  - set_i = (issue_en_1 & issue_dst_1==i) | (issue_en_2 & issue_dst_2==i);
  - clr_i = (wr_en_1 & wr_addr_1==i) | (wr_en_2 & wr_addr_2==i);
  - busy[i] <= set_i ? 1 : (clr_i ? 0 : busy[i]).
  - Set beats clear: a new producer issued in the same cycle as the old one retires keeps the bit busy.
  - Both slots issuing the same destination sets one bit.
  - A writeback to a non-busy register is legal and leaves the bit at 0.
- Hazard, combinational:
  - effbusy[i] = busy[i] & ~clr_i. A same-cycle writeback is bypassed, so it is not a hazard.
  - hazard_1 = (rd_en_a & effbusy[rd_addr_a]) | (rd_en_b & effbusy[rd_addr_b]).
  - hazard_2 = same form using ports c and d.
  - Current-cycle issue_* never affects the current-cycle hazards.
  - Disabled read ports never raise hazard.
- No internal stall logic: the consumer holds issue_en low while hazard is asserted. The block does not check this.
- Widths: no arithmetic; addresses are used unsigned and are always in range by construction.

Test Plan:
- Reset, then read all 8 addresses on ports a–d → all rd_data = 0x00000000, busy_vec = 8'h00, hazards = 0.
- Write r3 = 0xDEADBEEF (port 1) and r5 = 0x12345678 (port 2) in one cycle; next cycle read a=3, b=5 → 0xDEADBEEF, 0x12345678.
  - Same cycle, rd_addr_c = 3 → bypass returns 0xDEADBEEF before the edge.
- Both ports write r2 (port 1 = 0x11111111, port 2 = 0x22222222) → same-cycle read and later read both return 0x22222222.
- Issue dst r4 on slot 1 → busy_vec = 8'h10 after the edge. Then, with rd_en_c=1 and rd_addr_c=4:
  - hazard_2 = 1 while r4 is busy;
  - assert wr_en_1 to r4 with 0xCAFE0001 → hazard_2 drops to 0 in that same cycle and rd_data_c = 0xCAFE0001;
  - busy_vec = 8'h00 after the edge.
- Same cycle: writeback r6 and issue dst r6 on slot 2 → busy_vec[6] remains 1.
  - Then assert reset together with wr_en_1 to r1 = 0xFFFFFFFF and issue r7 → r1 reads 0, busy_vec = 8'h00.
